led_scheduler: RTL and testbench
================================

# led_scheduler

Sequencer/arbiter in front of the 24-bit memory-mapped LED output register. Shares the register's single write port between CPU IO stores and an autonomous pattern engine (blink, marquee, counter). The engine is configured through a control word at LED offset 2'b01, which the LED register itself ignores. Sits between the memory/IO decode (MemOrIO) and the LED register.

## Interface
- DIV, default 5_000_000: base prescaler period in clk cycles, ≥2.
- PRE_W, default 27: prescaler counter width; must hold DIV*8-1.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cpu_iowrite  in  1  CPU IO write strobe
- cpu_ledsel  in  1  LED region selected by the IO decoder
- cpu_addr  in  2  low address bits: 00 = LED[15:0], 01 = control, 10 = LED[23:16], 11 = unused
- cpu_wdata  in  16  CPU store data
- ledwrite  out  1  write strobe to the LED register
- led  out  1  LED select to the LED register
- ledaddr  out  2  offset to the LED register (00 or 10 only)
- ledwdata  out  16  data to the LED register
- eng_busy  out  1  engine FSM not in IDLE
- overrun  out  1  sticky: a tick was dropped while busy

## Operation
- Control register ctrl[5:0], written when cpu_iowrite & cpu_ledsel & addr==01. Bits [1:0] mode: 00 OFF, 01 BLINK, 10 MARQUEE, 11 COUNTER. Bits [5:4] period select p. Tick interval is DIV<<p cycles.
- A control write applies these changes on the next edge:
  - pat loads INIT(mode): BLINK 24'h000000, MARQUEE 24'h800000, COUNTER 24'h000000, OFF unchanged.
  - Prescaler clears to 0.
  - FSM goes to IDLE, aborting any in-flight sequence. The LED high half may stay stale.
  - overrun clears.
- Pattern advance: BLINK pat <= ~pat. MARQUEE rotate-left 1, so 24'h800000 wraps to 24'h000001. COUNTER pat+1, 24'hFFFFFF wraps to 0.
- CPU LED write (cpu_iowrite & cpu_ledsel & addr ∈ {00,10}) is forwarded combinationally in the same cycle: ledwrite=led=1, ledaddr=cpu_addr, ledwdata=cpu_wdata. The CPU always wins the write port. CPU writes to addr 11 are dropped.
- FSM states:
  - IDLE: if mode≠OFF and tick, then pat <= next(pat) and go to WR_LO.
  - WR_LO: if there is no CPU LED write this cycle, drive addr 00 with data pat[15:0] and go to WR_HI. Otherwise hold.
  - WR_HI: if there is no CPU LED write, drive addr 10 with data {8'h00, pat[23:16]} and go to IDLE. Otherwise hold.
- A tick arriving outside IDLE is dropped and sets overrun.
- Mode OFF: prescaler still runs, but the FSM stays in IDLE. Output is pure CPU pass-through.
- Priority in a single cycle: rst > control write > CPU LED write > engine write.

## Timing
- Reset values:
  - Outputs: ledwrite, led, ledaddr, ledwdata, eng_busy and overrun all 0.
  - Internal: ctrl=0 (OFF), pat=0, FSM IDLE, prescaler 0.
- Prescaler counts 0..(DIV<<p)-1. tick is a one-cycle pulse on the terminal count.
- Engine latency, uncontended: tick at cycle T, low write at T+1, high write at T+2, eng_busy deasserts at T+3.
- Each CPU LED write cycle stalls the engine by exactly one cycle. Engine state and pat are held during the stall.
- A control write in the same cycle as a tick: the control write wins and the tick is discarded without setting overrun.
- rst mid-sequence: everything returns to reset values immediately, with no write strobe issued.

## Configuration
- LED_SCHED_COUNTER_EN
  - Defined: mode 11 is COUNTER as above.
  - Undefined: mode 11 behaves exactly as OFF, and the incrementer logic is absent.

## Structure
- Package led_sched_pkg holds:
  - mode encodings: MODE_OFF, MODE_BLINK, MODE_MARQUEE, MODE_COUNTER;
  - offsets: ADDR_LO=2'b00, ADDR_CTRL=2'b01, ADDR_HI=2'b10;
  - the INIT pattern constants;
  - the FSM state typedef.
- Sub-module led_prescaler: the counter plus p-select, producing tick. Inputs are clear and p.

## Test plan
All scenarios use DIV=4.
- Reset, then CPU writes addr 00 with 16'h1234 → same cycle ledwrite=1, ledaddr=00, ledwdata=16'h1234. eng_busy stays 0.
- Write ctrl=6'h01 (BLINK, p=0) → first tick after 4 cycles. The next two cycles write 16'hFFFF@00, then 16'h00FF@10. The following pair writes 16'h0000 and 16'h0000.
- MARQUEE, p=0, run 24 ticks → the high-half write carries 8'h80 on tick 24. Tick 25 writes low 16'h0001 and high 8'h00.
- BLINK in WR_LO with CPU writes on 3 consecutive cycles → the CPU values appear on ledwdata. The engine low write occurs on the 4th cycle and the high write on the 5th.
- Hold a CPU write every cycle across two ticks → overrun=1. A following ctrl write clears overrun and returns the FSM to IDLE.
- Write ctrl=6'h03: with LED_SCHED_COUNTER_EN the first engine writes are 16'h0001 and 8'h00. Without the macro, no engine write ever occurs.

Source files
------------

// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared definitions for the LED scheduler slice.
//   - mode encodings held in ctrl[1:0]
//   - LED-region address offsets
//   - pattern values loaded when a mode is selected
//   - engine FSM state type
package led_sched_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_MARQUEE = 2'b10,
    MODE_COUNTER = 2'b11
  } mode_e;

  localparam logic [1:0] ADDR_LO   = 2'b00;
  localparam logic [1:0] ADDR_CTRL = 2'b01;
  localparam logic [1:0] ADDR_HI   = 2'b10;

  localparam logic [23:0] INIT_BLINK   = 24'h000000;
  localparam logic [23:0] INIT_MARQUEE = 24'h800000;
  localparam logic [23:0] INIT_COUNTER = 24'h000000;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWrLo = 2'b01,
    StWrHi = 2'b10
  } state_e;

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: free-running tick generator for the pattern engine.
// Counts 0..(DIV<<p)-1 and pulses tick for one cycle on the terminal count.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      synchronous restart from 0 (control write)
//   p          period select, interval = DIV << p cycles
//   tick       one-cycle pulse on terminal count
module led_prescaler
  import led_sched_pkg::*;
#(
  parameter int unsigned DIV   = 5_000_000,
  parameter int unsigned PRE_W = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [1:0] p,
  output logic       tick
);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] term;

  always_comb begin
    term = PRE_W'((DIV << p) - 32'd1);
    tick = (cnt_q == term);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_scheduler.sv
// led_scheduler: shares the LED register write port between CPU IO stores and
// an autonomous pattern engine (blink, marquee, counter).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cpu_iowrite   CPU IO write strobe
//   cpu_ledsel    LED region selected by the IO decoder
//   cpu_addr      00 = LED[15:0], 01 = control, 10 = LED[23:16], 11 = unused
//   cpu_wdata     CPU store data (ctrl uses [5:0])
//   ledwrite/led  write strobe and select to the LED register
//   ledaddr       00 or 10 only
//   ledwdata      data to the LED register
//   eng_busy      engine FSM not idle
//   overrun       sticky, a tick was dropped while busy
// Build option: define LED_SCHED_COUNTER_EN to enable COUNTER mode; otherwise
// mode 11 behaves as OFF and no incrementer is built.
module led_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned DIV   = 5_000_000,
  parameter int unsigned PRE_W = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_iowrite,
  input  logic        cpu_ledsel,
  input  logic [1:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        ledwrite,
  output logic        led,
  output logic [1:0]  ledaddr,
  output logic [15:0] ledwdata,
  output logic        eng_busy,
  output logic        overrun
);

  logic [5:0]  ctrl_q;
  logic [23:0] pat_q, pat_d, pat_next, pat_init;
  state_e      state_q, state_d;
  logic        overrun_q, overrun_d;

  logic        cpu_sel, ctrl_wr, cpu_led_wr;
  logic        tick, run;
  mode_e       mode, new_mode;
  logic        eng_wr;
  logic [1:0]  eng_addr;
  logic [15:0] eng_data;

  assign cpu_sel    = cpu_iowrite & cpu_ledsel;
  assign ctrl_wr    = cpu_sel & (cpu_addr == ADDR_CTRL);
  assign cpu_led_wr = cpu_sel & ((cpu_addr == ADDR_LO) | (cpu_addr == ADDR_HI));
  assign mode       = mode_e'(ctrl_q[1:0]);
  assign new_mode   = mode_e'(cpu_wdata[1:0]);

  led_prescaler #(
    .DIV   (DIV),
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (ctrl_wr),
    .p     (ctrl_q[5:4]),
    .tick  (tick)
  );

  // Modes that actually drive the engine.
  always_comb begin
`ifdef LED_SCHED_COUNTER_EN
    run = (mode != MODE_OFF);
`else
    run = (mode == MODE_BLINK) || (mode == MODE_MARQUEE);
`endif
  end

  always_comb begin
    pat_next = pat_q;
    case (mode)
      MODE_BLINK:   pat_next = ~pat_q;
      MODE_MARQUEE: pat_next = {pat_q[22:0], pat_q[23]};
`ifdef LED_SCHED_COUNTER_EN
      MODE_COUNTER: pat_next = pat_q + 24'd1;
`endif
      default:      pat_next = pat_q;
    endcase
  end

  // Pattern loaded by a control write; OFF (and disabled COUNTER) keep pat.
  always_comb begin
    pat_init = pat_q;
    case (new_mode)
      MODE_BLINK:   pat_init = INIT_BLINK;
      MODE_MARQUEE: pat_init = INIT_MARQUEE;
`ifdef LED_SCHED_COUNTER_EN
      MODE_COUNTER: pat_init = INIT_COUNTER;
`endif
      default:      pat_init = pat_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    overrun_d = overrun_q;
    eng_wr    = 1'b0;
    eng_addr  = ADDR_LO;
    eng_data  = '0;
    case (state_q)
      StIdle: begin
        if (run && tick) begin
          pat_d   = pat_next;
          state_d = StWrLo;
        end
      end
      StWrLo: begin
        eng_addr = ADDR_LO;
        eng_data = pat_q[15:0];
        if (!cpu_led_wr) begin
          eng_wr  = 1'b1;
          state_d = StWrHi;
        end
      end
      StWrHi: begin
        eng_addr = ADDR_HI;
        eng_data = {8'h00, pat_q[23:16]};
        if (!cpu_led_wr) begin
          eng_wr  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
    // Control write outranks everything the engine would do this cycle.
    if (ctrl_wr) begin
      state_d   = StIdle;
      pat_d     = pat_init;
      overrun_d = 1'b0;
      eng_wr    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      pat_q     <= '0;
      state_q   <= StIdle;
      overrun_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_q <= cpu_wdata[5:0];
      end
      pat_q     <= pat_d;
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs are forced low while rst is held so no strobe escapes mid-reset.
  always_comb begin
    ledwrite = 1'b0;
    led      = 1'b0;
    ledaddr  = '0;
    ledwdata = '0;
    if (!rst) begin
      if (cpu_led_wr) begin
        ledwrite = 1'b1;
        led      = 1'b1;
        ledaddr  = cpu_addr;
        ledwdata = cpu_wdata;
      end else if (eng_wr) begin
        ledwrite = 1'b1;
        led      = 1'b1;
        ledaddr  = eng_addr;
        ledwdata = eng_data;
      end
    end
  end

  assign eng_busy = (state_q != StIdle);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_led_scheduler.sv
// tb_led_scheduler: randomized + directed bench for led_scheduler (DIV=4).
// The reference model tracks the pattern as a number, the prescaler as a
// cycle count and the pending engine writes as a queue of (addr, data).
module tb_led_scheduler;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_iowrite;
  logic        cpu_ledsel;
  logic [1:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        ledwrite;
  logic        led;
  logic [1:0]  ledaddr;
  logic [15:0] ledwdata;
  logic        eng_busy;
  logic        overrun;

  led_scheduler #(
    .DIV   (DIV),
    .PRE_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_iowrite (cpu_iowrite),
    .cpu_ledsel  (cpu_ledsel),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .ledwrite    (ledwrite),
    .led         (led),
    .ledaddr     (ledaddr),
    .ledwdata    (ledwdata),
    .eng_busy    (eng_busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

`ifdef LED_SCHED_COUNTER_EN
  localparam bit CounterEn = 1'b1;
`else
  localparam bit CounterEn = 1'b0;
`endif

  // Reference model state.
  int          m_mode;
  int          m_p;
  int          m_cyc;
  logic [23:0] m_pat;
  bit          m_ovr;
  logic [17:0] m_q[$];   // {addr, data} of engine writes still to be issued
  int          n_eng_writes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_run(input int m);
    return (m == 1) || (m == 2) || (m == 3 && CounterEn);
  endfunction

  function automatic logic [23:0] m_adv(input int m, input logic [23:0] v);
    longint x = longint'(v);
    case (m)
      1: x = 64'd16777215 - x;
      2: x = (x * 2) % 64'd16777216 + x / 64'd8388608;
      3: x = (x + 1) % 64'd16777216;
      default: x = x;
    endcase
    return x[23:0];
  endfunction

  task automatic m_reset();
    m_mode = 0; m_p = 0; m_cyc = 0; m_pat = '0; m_ovr = 0;
    m_q.delete();
  endtask

  // One clock cycle: drive, compare against the model, advance both.
  task automatic cycle(input logic wr, input logic sel, input logic [1:0] a,
                       input logic [15:0] d);
    bit tick, busy, is_ctrl, is_led, eng;
    logic [1:0]  e_addr;
    logic [15:0] e_data;
    cpu_iowrite = wr; cpu_ledsel = sel; cpu_addr = a; cpu_wdata = d;
    #1;
    tick    = (m_cyc == (int'(DIV) << m_p) - 1);
    busy    = (m_q.size() != 0);
    is_ctrl = wr && sel && (a == 2'b01);
    is_led  = wr && sel && (a == 2'b00 || a == 2'b10);
    eng     = !is_led && !is_ctrl && busy;
    e_addr  = 2'b00;
    e_data  = 16'h0;
    if (is_led) begin
      e_addr = a; e_data = d;
    end else if (eng) begin
      e_addr = m_q[0][17:16]; e_data = m_q[0][15:0];
    end
    check("ledwrite", 32'(ledwrite), 32'(is_led || eng));
    check("led", 32'(led), 32'(is_led || eng));
    if (is_led || eng) begin
      check("ledaddr", 32'(ledaddr), 32'(e_addr));
      check("ledwdata", 32'(ledwdata), 32'(e_data));
    end
    check("eng_busy", 32'(eng_busy), 32'(busy));
    check("overrun", 32'(overrun), 32'(m_ovr));
    @(posedge clk);
    if (is_ctrl) begin
      m_mode = int'(d[1:0]);
      m_p    = int'(d[5:4]);
      if (m_mode == 1 || m_mode == 3 && CounterEn) m_pat = 24'h000000;
      else if (m_mode == 2) m_pat = 24'h800000;
      m_q.delete();
      m_ovr = 0;
      m_cyc = 0;
    end else begin
      m_cyc = tick ? 0 : m_cyc + 1;
      if (eng) begin
        void'(m_q.pop_front());
        n_eng_writes++;
      end
      if (tick) begin
        if (busy) begin
          m_ovr = 1;
        end else if (m_run(m_mode)) begin
          m_pat = m_adv(m_mode, m_pat);
          m_q.push_back({2'b00, m_pat[15:0]});
          m_q.push_back({2'b10, 8'h00, m_pat[23:16]});
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 16'(($urandom)));
  endtask

  task automatic ctrl(input logic [5:0] v);
    cycle(1'b1, 1'b1, 2'b01, {10'h0, v});
  endtask

  initial begin
    int k;
    cpu_iowrite = 0; cpu_ledsel = 0; cpu_addr = 0; cpu_wdata = 0;
    n_eng_writes = 0;
    rst = 1'b1;
    m_reset();
    #12;
    check("rst_ledwrite", 32'(ledwrite), 32'd0);
    check("rst_eng_busy", 32'(eng_busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ledwdata", 32'(ledwdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // CPU pass-through with engine off.
    cycle(1'b1, 1'b1, 2'b00, 16'h1234);
    idle(10);

    // BLINK p=0 then MARQUEE across the 24-tick wrap.
    ctrl(6'h01);
    idle(20);
    ctrl(6'h02);
    idle(25 * DIV + 6);

    // CPU stalls during WR_LO.
    ctrl(6'h01);
    k = 0;
    while (m_q.size() != 2 && k < 40) begin
      idle(1);
      k++;
    end
    check("reach_wr_lo", 32'(m_q.size()), 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 2'b10, 16'(($urandom)));
    idle(4);

    // Starve the engine until a tick is dropped, then clear with ctrl.
    for (int i = 0; i < 3 * DIV; i++) cycle(1'b1, 1'b1, 2'b00, 16'(($urandom)));
    check("overrun_set", 32'(overrun), 32'd1);
    ctrl(6'h01);
    check("overrun_clr", 32'(overrun), 32'd0);
    check("busy_clr", 32'(eng_busy), 32'd0);

    // COUNTER mode (OFF when the build option is absent).
    k = n_eng_writes;
    ctrl(6'h03);
    idle(30);
    check("counter_writes", 32'(n_eng_writes != k), 32'(CounterEn));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cycle(1'b1, 1'b1, 2'b01, {10'h0, 6'(($urandom))});
      end else if (r < 30) begin
        cycle(1'b1, 1'($urandom_range(0, 3) != 0), 2'(($urandom)), 16'(($urandom)));
      end else if (r < 35) begin
        cycle(1'b0, 1'b1, 2'(($urandom)), 16'(($urandom)));
      end else begin
        idle(1);
      end
    end

    // Reset in the middle of an engine sequence.
    ctrl(6'h02);
    k = 0;
    while (m_q.size() == 0 && k < 40) begin
      idle(1);
      k++;
    end
    check("reach_busy", 32'(m_q.size() != 0), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_ledwrite", 32'(ledwrite), 32'd0);
    check("midrst_busy", 32'(eng_busy), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
